layer0_input_packer: RTL and testbench

Front-end stage of the classifier that feeds the first LUT layer. It accepts raw unsigned feature words one per beat over a valid/ready stream and quantizes each to a 2-bit code against three per-feature thresholds. It assembles the codes into the packed input vector that the layer-0 neurons slice their 6-bit fan-in from, then holds that vector stable behind a valid/ready handshake until the network side consumes it.

---
 rtl/layer0_input_packer.sv | 167 ++++++++++++++++
 tb/tb_layer0_input_packer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/layer0_input_packer.sv
// Quantizes raw feature beats to 2-bit codes and packs them into the layer-0 input vector.
// Optional LAYER0_INPUT_PACKER_FRAME_CNT_EN adds a 16-bit count of consumed vectors.
module layer0_input_packer #(
    parameter int unsigned NUM_FEATURES = 64,
    parameter int unsigned IN_WIDTH     = 8,
    parameter int unsigned AW           = $clog2(NUM_FEATURES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [IN_WIDTH-1:0]       s_data,
    input  logic                      s_last,
    input  logic                      cfg_we,
    input  logic [AW-1:0]             cfg_addr,
    input  logic [3*IN_WIDTH-1:0]     cfg_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [2*NUM_FEATURES-1:0] m_data,
    output logic                      err
`ifdef LAYER0_INPUT_PACKER_FRAME_CNT_EN
    ,
    output logic [15:0]               frame_cnt
`endif
);

    localparam int unsigned DW = 2 * NUM_FEATURES;
    localparam int unsigned TW = 3 * IN_WIDTH;
    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_FEATURES - 1);
    localparam logic [IN_WIDTH-1:0] T0_RST = IN_WIDTH'(1 << (IN_WIDTH - 2));
    localparam logic [IN_WIDTH-1:0] T1_RST = IN_WIDTH'(2 << (IN_WIDTH - 2));
    localparam logic [IN_WIDTH-1:0] T2_RST = IN_WIDTH'(3 << (IN_WIDTH - 2));
    localparam logic [TW-1:0] THR_RST = {T2_RST, T1_RST, T0_RST};

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     m_data_q, m_data_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;
    logic              err_q, err_d;
    logic [TW-1:0]     thr_q [NUM_FEATURES];

    logic              accept_c;
    logic              handshake_c;
    logic              last_slot_c;
    logic              cfg_in_range_c;
    logic [TW-1:0]     thr_sel_c;
    logic [1:0]        code_c;

    assign accept_c       = s_valid && s_ready_q;
    assign handshake_c    = m_valid_q && m_ready;
    assign last_slot_c    = (idx_q == LAST_IDX);
    assign cfg_in_range_c = ({1'b0, cfg_addr} < (AW + 1)'(NUM_FEATURES));

    // Threshold table; the current beat reads the registered value, so a same-cycle write applies to later beats
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_FEATURES); i++) begin
                thr_q[i] <= THR_RST;
            end
        end else if (cfg_we && cfg_in_range_c) begin
            thr_q[cfg_addr] <= cfg_data;
        end
    end

    // Unordered thresholds simply yield the count of thresholds met
    always_comb begin
        thr_sel_c = thr_q[idx_q];
        code_c    = 2'({1'b0, s_data >= thr_sel_c[0*IN_WIDTH +: IN_WIDTH]})
                  + 2'({1'b0, s_data >= thr_sel_c[1*IN_WIDTH +: IN_WIDTH]})
                  + 2'({1'b0, s_data >= thr_sel_c[2*IN_WIDTH +: IN_WIDTH]});
    end

    // State register with registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= FILL;
            idx_q     <= '0;
            m_data_q  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            m_data_q  <= m_data_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
        end
    end

    // Next state, beat index and sticky framing error
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        case (state_q)
            FILL: begin
                if (accept_c) begin
                    if (s_last || last_slot_c) begin
                        state_d = HOLD;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                    // s_last either early or missing on the final slot
                    if (s_last != last_slot_c) begin
                        err_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (handshake_c) begin
                    state_d = FILL;
                end
            end
        endcase
    end

    // Slot write on acceptance, full clear once the vector is consumed
    always_comb begin
        m_data_d = m_data_q;
        if (accept_c) begin
            m_data_d[2*int'(idx_q) +: 2] = code_c;
        end
        if (handshake_c) begin
            m_data_d = '0;
        end
    end

    // Output decode from the next state so the ports come straight from flops
    always_comb begin
        s_ready_d = 1'b0;
        m_valid_d = 1'b0;
        case (state_d)
            FILL: s_ready_d = 1'b1;
            HOLD: m_valid_d = 1'b1;
        endcase
    end

    assign s_ready = s_ready_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign err     = err_q;

`ifdef LAYER0_INPUT_PACKER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Consumed-vector counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (handshake_c) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_layer0_input_packer.sv
// Directed self-checking bench for layer0_input_packer at NUM_FEATURES=4, IN_WIDTH=8.
module tb_layer0_input_packer;

    localparam int unsigned NF = 4;
    localparam int unsigned IW = 8;
    localparam int unsigned AW = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              s_valid;
    logic              s_ready;
    logic [IW-1:0]     s_data;
    logic              s_last;
    logic              cfg_we;
    logic [AW-1:0]     cfg_addr;
    logic [3*IW-1:0]   cfg_data;
    logic              m_valid;
    logic              m_ready;
    logic [2*NF-1:0]   m_data;
    logic              err;
`ifdef LAYER0_INPUT_PACKER_FRAME_CNT_EN
    logic [15:0]       frame_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int t_done [3];

    layer0_input_packer #(
        .NUM_FEATURES (NF),
        .IN_WIDTH     (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .err      (err)
`ifdef LAYER0_INPUT_PACKER_FRAME_CNT_EN
        ,
        .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input logic last);
        int w;
        w = 0;
        while (!s_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!s_ready) chk("beat_wait_timeout", 64'(s_ready), 64'd1);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic consume();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_err",     64'(err),     64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_s_ready", 64'(s_ready), 64'd1);

        // Default thresholds 64/128/192
        send_beat(8'd0, 1'b0);
        send_beat(8'd64, 1'b0);
        send_beat(8'd150, 1'b0);
        chk("t1_not_yet_valid", 64'(m_valid), 64'd0);
        send_beat(8'd255, 1'b1);
        chk("t1_m_valid", 64'(m_valid), 64'd1);
        chk("t1_s_ready", 64'(s_ready), 64'd0);
        chk("t1_m_data",  64'(m_data),  64'hE4);
        chk("t1_err",     64'(err),     64'd0);
        consume();
        chk("t1_hs_m_valid", 64'(m_valid), 64'd0);
        chk("t1_hs_s_ready", 64'(s_ready), 64'd1);
        chk("t1_hs_m_data",  64'(m_data),  64'd0);

        // Feature 1 thresholds {t2,t1,t0} = {200,100,10}
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = {8'd200, 8'd100, 8'd10};
        @(negedge clk);
        cfg_we = 1'b0;
        repeat (3) send_beat(8'd50, 1'b0);
        send_beat(8'd50, 1'b1);
        chk("t2_m_data", 64'(m_data), 64'h04);

        // Backpressure: vector held, extra beats refused
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1; s_data = 8'd255; s_last = 1'b1;
            @(negedge clk);
            chk("hold_m_data",  64'(m_data),  64'h04);
            chk("hold_s_ready", 64'(s_ready), 64'd0);
            chk("hold_m_valid", 64'(m_valid), 64'd1);
        end
        s_valid = 1'b0; s_last = 1'b0;
        consume();
        chk("hold_rel_s_ready", 64'(s_ready), 64'd1);
        chk("hold_rel_m_valid", 64'(m_valid), 64'd0);
        chk("hold_rel_m_data",  64'(m_data),  64'd0);

        // Early s_last: short vector, sticky err
        send_beat(8'd255, 1'b0);
        send_beat(8'd255, 1'b1);
        chk("t3_m_valid", 64'(m_valid), 64'd1);
        chk("t3_m_data",  64'(m_data),  64'h0F);
        chk("t3_err",     64'(err),     64'd1);
        consume();
        send_beat(8'd0, 1'b0);
        send_beat(8'd64, 1'b0);
        send_beat(8'd150, 1'b0);
        send_beat(8'd255, 1'b1);
        chk("t3_clean_m_data", 64'(m_data), 64'hE4);
        chk("t3_err_sticky",   64'(err),    64'd1);
        consume();

        // Reset mid-vector discards partial codes and err
        send_beat(8'd255, 1'b0);
        send_beat(8'd255, 1'b0);
        do_reset();
        chk("t4_rst_m_data",  64'(m_data),  64'd0);
        chk("t4_rst_err",     64'(err),     64'd0);
        chk("t4_rst_m_valid", 64'(m_valid), 64'd0);
        chk("t4_rst_s_ready", 64'(s_ready), 64'd1);
        repeat (3) send_beat(8'd255, 1'b0);
        send_beat(8'd255, 1'b1);
        chk("t4_m_data", 64'(m_data), 64'hFF);
        chk("t4_err",    64'(err),    64'd0);
        consume();

        // Missing s_last on final slot still closes the vector, sets err
        send_beat(8'd0, 1'b0);
        send_beat(8'd0, 1'b0);
        send_beat(8'd0, 1'b0);
        send_beat(8'd200, 1'b0);
        chk("t5_m_valid", 64'(m_valid), 64'd1);
        chk("t5_m_data",  64'(m_data),  64'hC0);
        chk("t5_err",     64'(err),     64'd1);
        consume();
        send_beat(8'd64, 1'b1);
        chk("t5_next_m_data", 64'(m_data), 64'h01);
        consume();

        // cfg write in the acceptance cycle: that beat uses the old thresholds
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = {8'd1, 8'd1, 8'd1};
        send_beat(8'd50, 1'b0);
        cfg_we = 1'b0;
        send_beat(8'd50, 1'b0);
        send_beat(8'd50, 1'b0);
        send_beat(8'd50, 1'b1);
        chk("t6_old_thr_m_data", 64'(m_data), 64'h00);
        consume();
        repeat (3) send_beat(8'd50, 1'b0);
        send_beat(8'd50, 1'b1);
        chk("t6_new_thr_m_data", 64'(m_data), 64'h03);
        consume();

        // Back-to-back vectors with m_ready tied high
        do_reset();
        m_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            repeat (3) send_beat(8'd255, 1'b0);
            send_beat(8'd255, 1'b1);
            t_done[v] = cyc;
            chk("t7_m_valid", 64'(m_valid), 64'd1);
            chk("t7_m_data",  64'(m_data),  64'hFF);
        end
        @(negedge clk);
        m_ready = 1'b0;
        chk("t7_period_a", 64'(t_done[1] - t_done[0]), 64'd5);
        chk("t7_period_b", 64'(t_done[2] - t_done[1]), 64'd5);
        chk("t7_final_m_valid", 64'(m_valid), 64'd0);
`ifdef LAYER0_INPUT_PACKER_FRAME_CNT_EN
        chk("t7_frame_cnt", 64'(frame_cnt), 64'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
